// File: rtl/fsk_demod_period_v2.sv
// Period-counting FSK demodulator: synchronises the comparator input, sums N
// rising-edge periods and classifies the sum against mark/space windows.
module fsk_demod_period_v2 #(
  parameter int CNT_W              = 14,
  parameter int PERIODS_TO_MEASURE = 2,
  parameter int MIN_PERIOD         = 20,
  parameter int TIMEOUT            = 10000,
  parameter int MARK_LO            = 142,
  parameter int MARK_HI            = 150,
  parameter int SPACE_LO           = 97,
  parameter int SPACE_HI           = 103,
  parameter int SYNC_STAGES        = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fsk_in,
  output logic               data_out,
  output logic               data_valid,
  output logic               bit_err,
  output logic               locked,
  output logic [CNT_W+4:0]   period_sum
);

  localparam int SUM_W = CNT_W + 5;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   MIN_P     = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [4:0]       LAST_IDX  = 5'(PERIODS_TO_MEASURE - 1);
  localparam logic [SUM_W-1:0] MARK_MIN  = SUM_W'(PERIODS_TO_MEASURE * MARK_LO);
  localparam logic [SUM_W-1:0] MARK_MAX  = SUM_W'(PERIODS_TO_MEASURE * MARK_HI);
  localparam logic [SUM_W-1:0] SPACE_MIN = SUM_W'(PERIODS_TO_MEASURE * SPACE_LO);
  localparam logic [SUM_W-1:0] SPACE_MAX = SUM_W'(PERIODS_TO_MEASURE * SPACE_HI);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [SUM_W-1:0]       r_sum;
  logic [4:0]             r_np;
  logic                   r_cls_go;
  logic [SUM_W-1:0]       r_cls_sum;
  logic                   r_data;
  logic                   r_valid;
  logic                   r_err;
  logic                   r_locked;
  logic [SUM_W-1:0]       r_psum;

  logic                   w_rise;
  logic [CNT_W:0]         w_p;
  logic                   w_start;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_timeout;
  logic [SUM_W-1:0]       w_sum_nxt;
  logic                   w_is_mark;
  logic                   w_is_space;

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_p        = {1'b0, r_cnt} + 1'b1;
  assign w_start    = (r_state == IDLE) && w_rise;
  assign w_accept   = (r_state == MEASURE) && w_rise && (w_p >= MIN_P);
  assign w_last     = w_accept && (r_np == LAST_IDX);
  // An edge in the timeout cycle takes priority over declaring carrier loss.
  assign w_timeout  = (r_state == MEASURE) && !w_rise && (r_cnt == TMO);
  assign w_sum_nxt  = r_sum + SUM_W'(w_p);
  assign w_is_mark  = (r_cls_sum >= MARK_MIN) && (r_cls_sum <= MARK_MAX);
  assign w_is_space = (r_cls_sum >= SPACE_MIN) && (r_cls_sum <= SPACE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start)   w_state_nxt = MEASURE;
    if (w_timeout) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_hist    <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_np      <= '0;
      r_cls_go  <= 1'b0;
      r_cls_sum <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], fsk_in};
      r_hist <= r_sync[SYNC_STAGES-1];

      if (w_start || w_accept) r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

      // The completing edge also opens the next window, so sum restarts at 0.
      if (w_start || w_timeout || w_last) begin
        r_sum <= '0;
        r_np  <= '0;
      end else if (w_accept) begin
        r_sum <= w_sum_nxt;
        r_np  <= r_np + 1'b1;
      end

      r_cls_go <= w_last;
      if (w_last) r_cls_sum <= w_sum_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_psum   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_cls_go) begin
        r_psum <= r_cls_sum;
        if (w_is_mark) begin
          r_data   <= 1'b1;
          r_valid  <= 1'b1;
          r_locked <= 1'b1;
        end else if (w_is_space) begin
          r_data   <= 1'b0;
          r_valid  <= 1'b1;
          r_locked <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_timeout) r_locked <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign bit_err    = r_err;
  assign locked     = r_locked;
  assign period_sum = r_psum;

endmodule

// File: tb/tb_fsk_demod_period_v2.sv
// Directed bench for fsk_demod_period_v2: expected decisions are queued as the
// waveform is issued and a monitor pops them whenever a strobe appears.
module tb_fsk_demod_period_v2;

  localparam int CNT_W = 14;
  localparam int SUM_W = CNT_W + 5;
  localparam int EW    = SUM_W + 2;

  logic             clk;
  logic             rst_n;
  logic             fsk_in;
  logic             data_out;
  logic             data_valid;
  logic             bit_err;
  logic             locked;
  logic [SUM_W-1:0] period_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: {is_err, expected data_out, expected period_sum}
  logic [EW-1:0] exp_q[$];

  fsk_demod_period_v2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsk_in     (fsk_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bit_err    (bit_err),
    .locked     (locked),
    .period_sum (period_sum)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ok(input logic b, input int sum);
    exp_q.push_back({1'b0, b, SUM_W'(sum)});
  endtask

  task automatic push_err(input logic hold, input int sum);
    exp_q.push_back({1'b1, hold, SUM_W'(sum)});
  endtask

  // n periods of length t, each starting with a rising edge
  task automatic wave(input int t, input int n);
    for (int i = 0; i < n; i++) begin
      fsk_in = 1'b1;
      wait_clks(t / 2);
      fsk_in = 1'b0;
      wait_clks(t - t / 2);
    end
  endtask

  // Same as wave() but with a short low notch early in the high phase,
  // producing a second rising edge well under the minimum period.
  task automatic wave_glitch(input int t, input int n);
    for (int i = 0; i < n; i++) begin
      fsk_in = 1'b1;
      wait_clks(8);
      fsk_in = 1'b0;
      wait_clks(3);
      fsk_in = 1'b1;
      wait_clks(t / 2 - 11);
      fsk_in = 1'b0;
      wait_clks(t - t / 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},   32'(data_out),   32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_bit_err"},    32'(bit_err),    32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_period_sum"}, 32'(period_sum), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (data_valid || bit_err) begin
        check("strobe_exclusive", 32'(data_valid & bit_err), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: valid=%0d err=%0d sum=%0d at %0t",
                   data_valid, bit_err, period_sum, $time);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_err", 32'(bit_err),    32'(e[EW-1]));
          check("data_out",        32'(data_out),   32'(e[EW-2]));
          check("period_sum",      32'(period_sum), 32'(e[SUM_W-1:0]));
          check("locked_at_strobe", 32'(locked),    32'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    fsk_in = 1'b0;
    wait_clks(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clks(5);
    check_all_zero("post_reset_idle");

    // Lock on mark: first rise only enters MEASURE
    push_ok(1'b1, 292);
    wave(146, 4);
    check("locked_after_mark", 32'(locked), 32'd1);

    // Gapless switch to space: the first space rise closes the 2nd mark window
    push_ok(1'b1, 292);
    push_ok(1'b0, 200);
    wave(100, 4);

    // Out-of-window periods: error strobes, data_out holds 0
    push_ok(1'b0, 200);
    push_err(1'b0, 250);
    wave(125, 4);
    check("locked_after_err", 32'(locked), 32'd1);
    check("data_hold_after_err", 32'(data_out), 32'd0);

    // Glitched mark wave behaves like the clean one
    push_err(1'b0, 250);
    push_ok(1'b1, 292);
    wave_glitch(146, 4);

    // Close the last window, then stop toggling
    push_ok(1'b1, 292);
    wave(146, 1);
    wait_clks(9700);
    check("locked_before_timeout", 32'(locked), 32'd1);
    wait_clks(300);
    check("locked_after_timeout", 32'(locked), 32'd0);
    check("data_hold_after_timeout", 32'(data_out), 32'd1);

    // Resume: first edge unmeasured, decision after two full periods
    push_ok(1'b1, 292);
    wave(146, 3);
    check("relock_after_resume", 32'(locked), 32'd1);

    // Reset partway through a window
    wave(146, 1);
    wait_clks(30);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    wait_clks(3);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    wait_clks(5);
    check_all_zero("after_reset_release");

    push_ok(1'b1, 292);
    wave(146, 3);
    wait_clks(20);
    check("locked_after_reset_relock", 32'(locked), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
